// File: rtl/mux_sel_pkg.sv
// Shared types and helpers for the mux select arbiter.
// Source indices map directly onto the 2-bit mux select {s0,s1}.
package mux_sel_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;
    localparam logic [1:0] SRC_D = 2'd3;

    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        return {idx[1], idx[0]};
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester scanning last+1, last+2, ... mod 4.
// Zero latency; no backpressure. The last winner is scanned last, so it gets lowest priority.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = last;
        cand  = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 4-source word mux selects; grant visible 1 cycle after req.
// Grant held until done, request withdrawal, or HOLD_MAX cycles elapse (timeout pulse).
module mux_sel_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       s0,
    output logic       s1,
    output logic       valid,
    output logic [3:0] grant,
    output logic       timeout
);
    import mux_sel_pkg::*;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic             pick_found;
    logic [1:0]       pick_idx;
    logic             cur_req;
    logic             release_now;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        sel_d       = sel_q;
        grant_d     = grant_q;
        valid_d     = valid_q;
        timeout_d   = 1'b0;
        cur_req     = |(req & grant_q);
        release_now = done || !cur_req || (cnt_q == HOLD_LAST);

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << pick_idx;
                    sel_d   = idx_to_sel(pick_idx);
                    last_d  = pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    cnt_d = '0;
                    // Only a pure hold expiry pulses timeout; done or withdrawal take precedence.
                    timeout_d = !done && cur_req;
                    if (pick_found) begin
                        grant_d = 4'b0001 << pick_idx;
                        sel_d   = idx_to_sel(pick_idx);
                        last_d  = pick_idx;
                        valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= SRC_D;
            sel_q     <= idx_to_sel(SRC_A);
            grant_q   <= 4'b0000;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign s0      = sel_q[1];
    assign s1      = sel_q[0];
    assign valid   = valid_q;
    assign grant   = grant_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: expected {grant,valid,s0,s1,timeout} queued per step.
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       s0, s1, valid, timeout;
    logic [3:0] grant;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[$];

    mux_sel_arbiter #(.HOLD_MAX(8), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .s0      (s0),
        .s1      (s1),
        .valid   (valid),
        .grant   (grant),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mk(input logic [3:0] g, input logic v,
                                      input logic [1:0] sel, input logic t);
        return {g, v, sel, t};
    endfunction

    function automatic logic [7:0] obs();
        return {grant, valid, s0, s1, timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between edges; leaves time at edge+3.
    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got, e;
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        tick();
        sb.push_back(mk(4'b0000, 1'b0, 2'b00, 1'b0));
        got = obs(); e = sb.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", got, e);
        end
        #2;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] rq [3] = '{4'b0100, 4'b0100, 4'b0000};
        logic       dn [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] ex [3] = '{8'b0100_1_10_0, 8'b0100_1_10_0, 8'b0000_0_10_0};
        logic [7:0] got, e;
        for (int i = 0; i < 3; i++) begin
            req = rq[i]; done = dn[i];
            sb.push_back(ex[i]);
            tick();
            got = obs(); e = sb.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL single step %0d: got %b expected %b", i, got, e);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        logic [7:0] got, e;
        pulse_reset();
        req = 4'b0010; done = 1'b0;
        sb.push_back(mk(4'b0010, 1'b1, 2'b01, 1'b0));
        tick();
        got = obs(); e = sb.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL mid_grant_b: got %b expected %b", got, e);
        end
        #2;
        rst = 1'b1;
        #1;
        sb.push_back(mk(4'b0000, 1'b0, 2'b00, 1'b0));
        got = obs(); e = sb.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected %b", got, e);
        end
        #1;
        rst = 1'b0;
        req = 4'b1111;
        sb.push_back(mk(4'b0001, 1'b1, 2'b00, 1'b0));
        tick();
        got = obs(); e = sb.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL post_reset_a: got %b expected %b", got, e);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_rotation();
        logic [3:0] rq [7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
        logic       dn [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] ex [7] = '{8'b0001_1_00_0, 8'b0010_1_01_0, 8'b0100_1_10_0, 8'b1000_1_11_0,
                               8'b0001_1_00_0, 8'b0000_0_00_0, 8'b0000_0_00_0};
        logic [7:0] got, e;
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            req = rq[i]; done = dn[i];
            sb.push_back(ex[i]);
            tick();
            got = obs(); e = sb.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL rotation step %0d: got %b expected %b", i, got, e);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_timeout();
        logic [7:0] got, e;
        pulse_reset();
        req = 4'b0011; done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8)       sb.push_back(mk(4'b0001, 1'b1, 2'b00, 1'b0));
            else if (i == 8) sb.push_back(mk(4'b0010, 1'b1, 2'b01, 1'b1));
            else             sb.push_back(mk(4'b0010, 1'b1, 2'b01, 1'b0));
            tick();
            got = obs(); e = sb.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL timeout step %0d: got %b expected %b", i, got, e);
            end
        end
    endtask

    // Continues from test_timeout: b granted with req=0011.
    task automatic test_withdrawal();
        logic [3:0] rq [2] = '{4'b1000, 4'b0000};
        logic [7:0] ex [2] = '{8'b1000_1_11_0, 8'b0000_0_11_0};
        logic [7:0] got, e;
        done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req = rq[i];
            sb.push_back(ex[i]);
            tick();
            got = obs(); e = sb.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL withdrawal step %0d: got %b expected %b", i, got, e);
            end
        end
    endtask

    // Release exactly on the hold boundary by done+drop or by drop alone: no timeout pulse.
    task automatic test_boundary_release(input logic with_done);
        logic [7:0] got, e;
        pulse_reset();
        req = 4'b0001; done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) begin
                req = 4'b0000; done = with_done;
            end else if (i == 9) begin
                done = 1'b0;
            end
            if (i < 8) sb.push_back(mk(4'b0001, 1'b1, 2'b00, 1'b0));
            else       sb.push_back(mk(4'b0000, 1'b0, 2'b00, 1'b0));
            tick();
            got = obs(); e = sb.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL boundary(done=%0b) step %0d: got %b expected %b",
                         with_done, i, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid_grant();
        test_rotation();
        test_timeout();
        test_withdrawal();
        test_boundary_release(1'b1);
        test_boundary_release(1'b0);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
